// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder fronting a small word-organised memory with byte/halfword/word lanes.
// Latency: data phase follows the address phase after WAIT_STATES stall cycles; errors take two cycles.
// Backpressure: stalls the bus via hreadyout during wait states and the first ERROR cycle.
module ahb_slave_mem #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     cnt_q;
  logic [AW-1:0]  idx_q;
  logic [1:0]     off_q;
  logic           wr_q;
  logic [2:0]     size_q;
  logic [31:0]    hrdata_q;
  logic [31:0]    mem [DEPTH];

  logic           accept;
  logic           cap;
  logic           addr_bad;
  logic           size_bad;
  logic           misalign;
  logic           illegal;
  state_t         cap_next;
  logic           rd_phase;
  logic           wr_commit;
  logic [31:0]    lane_mask;

  // A new address phase is only taken in states where this slave is ready.
  assign accept   = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign cap      = hsel & hready & htrans[1] & accept;
  assign addr_bad = (haddr >= ADDR_W'(4 * DEPTH));
  assign size_bad = (hsize > 3'b010);
  assign misalign = ((hsize == 3'b001) && haddr[0]) ||
                    ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
  assign illegal  = addr_bad | size_bad | misalign;
  assign cap_next = illegal ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DATA);

  assign rd_phase  = (state_q == S_DATA) && !wr_q;
  assign wr_commit = (state_q == S_DATA) && wr_q;

  // Next-state and bus response decode.
  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cap) state_d = cap_next;
      end
      S_WAIT: begin
        hreadyout = 1'b0;
        if (cnt_q == 3'd0) state_d = S_DATA;
      end
      S_DATA: begin
        state_d = cap ? cap_next : S_IDLE;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        hresp   = 1'b1;
        state_d = cap ? cap_next : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Wait-state counter: loads at capture, counts down while stalling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   cnt_q <= 3'd0;
    else if (cap)                                cnt_q <= WS_LOAD;
    else if (state_q == S_WAIT && cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
  end

  // Address-phase capture of the transfer attributes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      off_q  <= 2'b00;
      wr_q   <= 1'b0;
      size_q <= 3'b000;
    end else if (cap) begin
      idx_q  <= haddr[AW+1:2];
      off_q  <= haddr[1:0];
      wr_q   <= hwrite;
      size_q <= hsize;
    end
  end

  // Little-endian byte-lane enables for the committed write.
  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    case (size_q)
      3'b000:  lane_mask = 32'h0000_00FF << {off_q, 3'b000};
      3'b001:  lane_mask = off_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
  end

  // Memory: cleared by reset, write merged on the edge that leaves DATA.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (wr_commit) begin
      mem[idx_q] <= (mem[idx_q] & ~lane_mask) | (hwdata & lane_mask);
    end
  end

  // Read data is live in a read data phase and held afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         hrdata_q <= 32'h0;
    else if (rd_phase) hrdata_q <= mem[idx_q];
  end

  assign hrdata = rd_phase ? mem[idx_q] : hrdata_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: one instance with zero and one with three wait states.
// Each slave's hready is looped back from its own hreadyout (single-slave bus).
// Transfers are driven at the falling edge and observed at the falling edge.
module tb_ahb_slave_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hreadyout0, hresp0, hreadyout3, hresp3;
  logic [31:0] hrdata0, hrdata3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ahb_slave_mem #(.DEPTH(16), .WAIT_STATES(0), .ADDR_W(32)) dut0 (
    .clk(clk), .reset(reset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hreadyout0),
    .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0)
  );

  ahb_slave_mem #(.DEPTH(16), .WAIT_STATES(3), .ADDR_W(32)) dut3 (
    .clk(clk), .reset(reset), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hreadyout3),
    .hreadyout(hreadyout3), .hresp(hresp3), .hrdata(hrdata3)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle_bus();
    hsel0  = 1'b0;
    hsel3  = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic addr_phase(input bit d3, input bit wr, input logic [31:0] a, input logic [2:0] sz);
    hsel0  = !d3;
    hsel3  = d3;
    htrans = 2'b10;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask

  // One complete transfer; reports stall count, ERROR seen while stalled, final response.
  task automatic xfer(input bit d3, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output int nlow,
                      output logic rlow, output logic rend);
    bit done;
    @(negedge clk);
    addr_phase(d3, wr, a, sz);
    @(posedge clk);
    #1;
    idle_bus();
    hwdata = wd;
    nlow = 0;
    rlow = 1'b0;
    rend = 1'b0;
    rd   = 32'h0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if ((d3 ? hreadyout3 : hreadyout0) == 1'b1) begin
        rd   = d3 ? hrdata3 : hrdata0;
        rend = d3 ? hresp3 : hresp0;
        done = 1'b1;
      end else begin
        nlow++;
        rlow = rlow | (d3 ? hresp3 : hresp0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  int          nlow;
  logic        rlow, rend;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    idle_bus();
    haddr  = 32'h0;
    hwrite = 1'b0;
    hsize  = 3'b000;
    hwdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(hreadyout0), 32'h1);
    chk("rst_resp", 32'(hresp0), 32'h0);
    chk("rst_rdata", hrdata0, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Read after reset returns zero with no stall.
    xfer(0, 0, 32'h24, 3'b010, 32'h0, rd, nlow, rlow, rend);
    chk("rd0_data", rd, 32'h0);
    chk("rd0_nlow", 32'(nlow), 32'h0);
    chk("rd0_resp", 32'(rend), 32'h0);

    // Word write then read.
    xfer(0, 1, 32'h24, 3'b010, 32'h0000_0001, rd, nlow, rlow, rend);
    chk("wr24_nlow", 32'(nlow), 32'h0);
    xfer(0, 0, 32'h24, 3'b010, 32'h0, rd, nlow, rlow, rend);
    chk("rd24_data", rd, 32'h0000_0001);

    // Byte lanes.
    xfer(0, 1, 32'h18, 3'b010, 32'h1122_3344, rd, nlow, rlow, rend);
    xfer(0, 1, 32'h1A, 3'b000, 32'h00AB_0000, rd, nlow, rlow, rend);
    xfer(0, 1, 32'h18, 3'b001, 32'h0000_BEEF, rd, nlow, rlow, rend);
    xfer(0, 0, 32'h18, 3'b010, 32'h0, rd, nlow, rlow, rend);
    chk("lanes_18", rd, 32'h11AB_BEEF);
    xfer(0, 1, 32'h1E, 3'b001, 32'hCAFE_0000, rd, nlow, rlow, rend);
    xfer(0, 0, 32'h1C, 3'b010, 32'h0, rd, nlow, rlow, rend);
    chk("half_hi_1c", rd, 32'hCAFE_0000);

    // Back-to-back write then read of the same word.
    @(negedge clk);
    addr_phase(0, 1, 32'h30, 3'b010);
    @(posedge clk);
    #1;
    addr_phase(0, 0, 32'h30, 3'b010);
    hwdata = 32'hA5A5_0F0F;
    @(posedge clk);
    #1;
    idle_bus();
    @(negedge clk);
    chk("b2b_ready", 32'(hreadyout0), 32'h1);
    chk("b2b_data", hrdata0, 32'hA5A5_0F0F);
    @(posedge clk);
    #1;

    // Three wait states on write and read.
    xfer(1, 1, 32'h04, 3'b010, 32'h0000_01B1, rd, nlow, rlow, rend);
    chk("ws_wr_nlow", 32'(nlow), 32'h3);
    chk("ws_wr_resp", 32'(rend), 32'h0);
    xfer(1, 0, 32'h04, 3'b010, 32'h0, rd, nlow, rlow, rend);
    chk("ws_rd_nlow", 32'(nlow), 32'h3);
    chk("ws_rd_data", rd, 32'h0000_01B1);

    // Out-of-range read.
    xfer(0, 0, 32'h40, 3'b010, 32'h0, rd, nlow, rlow, rend);
    chk("oor_err1_low", 32'(nlow), 32'h1);
    chk("oor_err1_resp", 32'(rlow), 32'h1);
    chk("oor_err2_resp", 32'(rend), 32'h1);

    // Misaligned write leaves memory untouched.
    xfer(0, 1, 32'h04, 3'b010, 32'h1234_5678, rd, nlow, rlow, rend);
    xfer(0, 1, 32'h06, 3'b010, 32'hDEAD_BEEF, rd, nlow, rlow, rend);
    chk("mis_nlow", 32'(nlow), 32'h1);
    chk("mis_resp", 32'(rend), 32'h1);
    xfer(0, 0, 32'h04, 3'b010, 32'h0, rd, nlow, rlow, rend);
    chk("mis_mem", rd, 32'h1234_5678);

    // Illegal size.
    xfer(0, 0, 32'h00, 3'b011, 32'h0, rd, nlow, rlow, rend);
    chk("size_resp", 32'(rend), 32'h1);

    // Unselected and BUSY transfers start nothing.
    @(negedge clk);
    addr_phase(0, 1, 32'h08, 3'b010);
    hsel0 = 1'b0;
    @(posedge clk);
    #1;
    idle_bus();
    hwdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("nosel_ready", 32'(hreadyout0), 32'h1);
    @(negedge clk);
    addr_phase(0, 1, 32'h08, 3'b010);
    htrans = 2'b01;
    @(posedge clk);
    #1;
    idle_bus();
    hwdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("busy_ready", 32'(hreadyout0), 32'h1);
    xfer(0, 0, 32'h08, 3'b010, 32'h0, rd, nlow, rlow, rend);
    chk("busy_mem", rd, 32'h0);

    // Reset during wait states of a write.
    @(negedge clk);
    addr_phase(1, 1, 32'h08, 3'b010);
    @(posedge clk);
    #1;
    idle_bus();
    hwdata = 32'h0000_0045;
    @(negedge clk);
    chk("mid_wait_low", 32'(hreadyout3), 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(hreadyout3), 32'h1);
    chk("mid_rst_resp", 32'(hresp3), 32'h0);
    chk("mid_rst_rdata", hrdata3, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    xfer(1, 0, 32'h08, 3'b010, 32'h0, rd, nlow, rlow, rend);
    chk("mid_rd_data", rd, 32'h0);
    chk("mid_rd_nlow", 32'(nlow), 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
